aes_dec_key_sched: RTL and testbench

//  Sequential round-key source for the AES decryption datapath. It takes the cipher key, runs the key

---
 rtl/aes_key_pkg.sv | 75 +++++++
 rtl/aes_sbox_word.sv | 13 +
 rtl/aes_dec_key_sched.sv | 195 +++++++++++++++++++
 tb/tb_aes_dec_key_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES decryption key scheduler: key-length codes, round-count
// lookups, the rcon table, the byte S-box and the scheduler FSM state type.
package aes_key_pkg;

  localparam logic [1:0] KLEN_128 = 2'b00;
  localparam logic [1:0] KLEN_192 = 2'b01;
  localparam logic [1:0] KLEN_256 = 2'b10;
  localparam logic [1:0] KLEN_BAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StRev
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row-major S-box, entry x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [10:0] top;
    top = 11'd2047 - {x, 3'b000};
    return SBOX_TBL[top -: 8];
  endfunction

  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [3:0] klen_nk(input logic [1:0] klen);
    case (klen)
      KLEN_192: return 4'd6;
      KLEN_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] klen_nr(input logic [1:0] klen);
    case (klen)
      KLEN_192: return 4'd12;
      KLEN_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  // Nw - Nk: number of forward steps until the window top holds w[Nw-1].
  function automatic logic [5:0] klen_fwd_steps(input logic [1:0] klen);
    case (klen)
      KLEN_192: return 6'd46;
      KLEN_256: return 6'd52;
      default:  return 6'd40;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES byte S-boxes forming one 32-bit SubWord.
module aes_sbox_word
  import aes_key_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = sbox_byte(i_word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Round-key source for AES decryption: runs the schedule forward to the last round key, then
// regenerates words backwards and streams round keys Nr..0 over valid/ready.
module aes_dec_key_sched
  import aes_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_lenth,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         err_len
);

  state_e       r_state;
  logic [31:0]  r_win [8];
  logic [5:0]   r_j;
  logic [2:0]   r_imod;
  logic [3:0]   r_idiv;
  logic [3:0]   r_nk;
  logic [3:0]   r_nr;
  logic [5:0]   r_fwd_steps;
  logic [3:0]   r_next;
  logic         r_all_loaded;
  logic         r_busy;
  logic         r_rk_valid;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_round;
  logic         r_rk_last;
  logic         r_err_len;

  logic [2:0]   w_top_idx;
  logic [2:0]   w_sub_idx;
  logic [2:0]   w_off;
  logic         w_mod0;
  logic         w_mod4;
  logic [31:0]  w_t_in;
  logic [31:0]  w_base;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_t_out;
  logic [31:0]  w_new_word;
  logic [5:0]   w_base_word;
  logic [5:0]   w_tgt_word;
  logic [3:0]   w_tgt;
  logic         w_in_win;
  logic         w_accept;
  logic         w_load;
  logic         w_shift;
  logic [127:0] w_rk_next;

  // FWD feeds T from the window top; REV feeds it from the word just below the top.
  always_comb begin
    w_top_idx = 3'(r_nk - 4'd1);
    w_sub_idx = 3'(r_nk - 4'd2);
    w_mod0    = (r_imod == 3'd0);
    w_mod4    = (r_nk == 4'd8) && (r_imod == 3'd4);
    if (r_state == StRev) begin
      w_t_in = r_win[w_sub_idx];
      w_base = r_win[w_top_idx];
    end else begin
      w_t_in = r_win[w_top_idx];
      w_base = r_win[0];
    end
    w_sub_in = w_mod0 ? {w_t_in[23:0], w_t_in[31:24]} : w_t_in;
  end

  aes_sbox_word u_sbox (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_t_out = w_t_in;
    if (w_mod0) begin
      w_t_out = w_sub_out ^ {rcon_at(r_idiv - 4'd1), 24'h000000};
    end else if (w_mod4) begin
      w_t_out = w_sub_out;
    end
    w_new_word = w_base ^ w_t_out;

    w_base_word = {r_next, 2'b00};
    w_in_win    = (r_j <= w_base_word) &&
                  (({1'b0, w_base_word} + 7'd4) <= ({1'b0, r_j} + {3'b000, r_nk}));
    w_off       = 3'(w_base_word - r_j);
    w_rk_next   = {r_win[w_off], r_win[w_off + 3'd1], r_win[w_off + 3'd2], r_win[w_off + 3'd3]};

    w_accept = r_rk_valid && rk_ready;
    w_load   = (r_state == StRev) && !r_all_loaded && w_in_win && (!r_rk_valid || rk_ready);
    // Aim the window at the round after the one being loaded so keys stream every 4 cycles.
    w_tgt      = w_load ? (r_next - 4'd1) : r_next;
    w_tgt_word = {w_tgt, 2'b00};
    w_shift    = (r_state == StRev) && !r_all_loaded && !(w_load && (r_next == 4'd0)) &&
                 (r_j > w_tgt_word);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
      r_j          <= 6'd0;
      r_imod       <= 3'd0;
      r_idiv       <= 4'd1;
      r_nk         <= 4'd4;
      r_nr         <= 4'd10;
      r_fwd_steps  <= 6'd40;
      r_next       <= 4'd0;
      r_all_loaded <= 1'b0;
      r_busy       <= 1'b0;
      r_rk_valid   <= 1'b0;
      r_rk_data    <= 128'h0;
      r_rk_round   <= 4'd0;
      r_rk_last    <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (key_lenth == KLEN_BAD) begin
              r_err_len <= 1'b1;
            end else begin
              for (int k = 0; k < 8; k++) r_win[k] <= key_in[255 - 32*k -: 32];
              r_j          <= 6'd0;
              r_imod       <= 3'd0;
              r_idiv       <= 4'd1;
              r_nk         <= klen_nk(key_lenth);
              r_nr         <= klen_nr(key_lenth);
              r_fwd_steps  <= klen_fwd_steps(key_lenth);
              r_all_loaded <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= StFwd;
            end
          end
        end
        StFwd: begin
          for (int k = 0; k < 7; k++) r_win[k] <= r_win[k + 1];
          r_win[w_top_idx] <= w_new_word;
          r_j <= r_j + 6'd1;
          if ((r_j + 6'd1) == r_fwd_steps) begin
            // Word index stays at Nw-1: the first reverse step undoes exactly that word.
            r_next  <= r_nr;
            r_state <= StRev;
          end else if (r_imod == w_top_idx) begin
            r_imod <= 3'd0;
            r_idiv <= r_idiv + 4'd1;
          end else begin
            r_imod <= r_imod + 3'd1;
          end
        end
        StRev: begin
          if (w_shift) begin
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k - 1];
            r_win[0] <= w_new_word;
            r_j      <= r_j - 6'd1;
            if (r_imod == 3'd0) begin
              r_imod <= w_top_idx;
              r_idiv <= r_idiv - 4'd1;
            end else begin
              r_imod <= r_imod - 3'd1;
            end
          end
          if (w_load) begin
            r_rk_valid <= 1'b1;
            r_rk_data  <= w_rk_next;
            r_rk_round <= r_next;
            r_rk_last  <= (r_next == 4'd0);
            if (r_next == 4'd0) r_all_loaded <= 1'b1;
            else                r_next       <= r_next - 4'd1;
          end else if (w_accept) begin
            r_rk_valid <= 1'b0;
          end
          if (w_accept && r_rk_last) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_rk_valid;
  assign rk_data  = r_rk_data;
  assign rk_round = r_rk_round;
  assign rk_last  = r_rk_last;
  assign err_len  = r_err_len;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for aes_dec_key_sched: FIPS-197 key schedules, backpressure, rejected starts
// and mid-run resets.
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_lenth = 2'b00;
  logic [255:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         busy, rk_valid, rk_last, err_len;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  aes_dec_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_lenth (key_lenth),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .err_len   (err_len)
  );

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                     64'h0};
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int total = 0;
  int bad = 0;

  logic [127:0] exp128 [11];
  logic [127:0] got_data [16];
  logic [3:0]   got_round [16];
  logic         got_last [16];
  int           got_n, first_cyc, unstable;
  logic         timed_out;

  task automatic start_key(input logic [1:0] len, input logic [255:0] key);
    key_lenth = len;
    key_in    = key;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Consumes keys until rk_last is accepted; cycle c means c rising edges after the start edge.
  task automatic collect(input int ready_pct, input int budget, input bit start_at_last);
    logic         held;
    logic [127:0] h_data;
    logic [3:0]   h_round;
    logic         h_last;
    got_n = 0; first_cyc = -1; unstable = 0; timed_out = 1'b1; held = 1'b0;
    h_data = '0; h_round = '0; h_last = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (held && (!rk_valid || rk_data !== h_data || rk_round !== h_round || rk_last !== h_last))
        unstable++;
      if (rk_valid && first_cyc < 0) first_cyc = c;
      rk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (rk_valid && rk_ready) begin
        if (got_n < 16) begin
          got_data[got_n] = rk_data; got_round[got_n] = rk_round; got_last[got_n] = rk_last;
        end
        got_n++;
        held = 1'b0;
        if (rk_last) begin
          if (start_at_last) begin
            key_lenth = KLEN128(); key_in = KEY128; start = 1'b1;
          end
          timed_out = 1'b0;
          break;
        end
      end else if (rk_valid) begin
        held = 1'b1; h_data = rk_data; h_round = rk_round; h_last = rk_last;
      end else begin
        held = 1'b0;
      end
    end
    @(negedge clk);
    start    = 1'b0;
    rk_ready = 1'b0;
  endtask

  function automatic logic [1:0] KLEN128();
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
    total++; if (rk_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", rk_last); end
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_len); end
    total++; if (rk_data !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rk_data); end
    total++; if (rk_round !== 4'd0) begin bad++; $display("FAIL reset_round: got %0d want 0", rk_round); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aes128();
    int viol;
    start_key(2'b00, KEY128);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a128_busy_rise: got %b want 1", busy); end
    collect(100, 200, 1'b1);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL a128_timeout: got %b want 0", timed_out); end
    total++; if (first_cyc !== 41) begin bad++; $display("FAIL a128_latency: got %0d want 41", first_cyc); end
    total++; if (got_n !== 11) begin bad++; $display("FAIL a128_count: got %0d want 11", got_n); end
    for (int k = 0; k < 11 && k < got_n; k++) begin
      total++;
      if (got_data[k] !== exp128[10-k]) begin
        bad++; $display("FAIL a128_key%0d: got %h want %h", 10-k, got_data[k], exp128[10-k]);
      end
      total++;
      if (got_round[k] !== 4'(10-k)) begin
        bad++; $display("FAIL a128_round: got %0d want %0d", got_round[k], 10-k);
      end
      total++;
      if (got_last[k] !== (k == 10)) begin
        bad++; $display("FAIL a128_last%0d: got %b want %b", k, got_last[k], k == 10);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a128_busy_fall: got %b want 0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("FAIL a128_valid_fall: got %b want 0", rk_valid); end
    // The start raised alongside the final acceptance must not have launched a new run.
    viol = 0;
    rk_ready = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || rk_valid !== 1'b0) viol++;
    end
    rk_ready = 1'b0;
    total++; if (viol !== 0) begin bad++; $display("FAIL a128_start_at_last: got %0d busy cycles want 0", viol); end
  endtask

  task automatic test_aes192();
    int viol;
    start_key(2'b01, KEY192);
    collect(100, 200, 1'b0);
    total++; if (first_cyc !== 47) begin bad++; $display("FAIL a192_latency: got %0d want 47", first_cyc); end
    total++; if (got_n !== 13) begin bad++; $display("FAIL a192_count: got %0d want 13", got_n); end
    total++;
    if (got_data[0] !== 128'ha4970a331a78dc09c418c271e3a41d5d || got_round[0] !== 4'd12) begin
      bad++; $display("FAIL a192_first: got %0d/%h want 12/a4970a331a78dc09c418c271e3a41d5d",
                      got_round[0], got_data[0]);
    end
    total++;
    if (got_data[12] !== 128'h000102030405060708090a0b0c0d0e0f || got_last[12] !== 1'b1) begin
      bad++; $display("FAIL a192_round0: got %h last=%b want 000102..0f last=1",
                      got_data[12], got_last[12]);
    end
    viol = 0;
    for (int k = 1; k < got_n && k < 16; k++) if (got_round[k] >= got_round[k-1]) viol++;
    total++; if (viol !== 0) begin bad++; $display("FAIL a192_order: got %0d violations want 0", viol); end
  endtask

  task automatic test_aes256();
    start_key(2'b10, KEY256);
    collect(100, 200, 1'b0);
    total++; if (first_cyc !== 53) begin bad++; $display("FAIL a256_latency: got %0d want 53", first_cyc); end
    total++; if (got_n !== 15) begin bad++; $display("FAIL a256_count: got %0d want 15", got_n); end
    total++;
    if (got_data[0] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      bad++; $display("FAIL a256_round14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", got_data[0]);
    end
    total++;
    if (got_data[13] !== 128'h101112131415161718191a1b1c1d1e1f || got_round[13] !== 4'd1) begin
      bad++; $display("FAIL a256_round1: got %0d/%h want 1/101112..1f", got_round[13], got_data[13]);
    end
    total++;
    if (got_data[14] !== 128'h000102030405060708090a0b0c0d0e0f || got_last[14] !== 1'b1) begin
      bad++; $display("FAIL a256_round0: got %h last=%b want 000102..0f last=1",
                      got_data[14], got_last[14]);
    end
  endtask

  task automatic test_backpressure();
    start_key(2'b00, KEY128);
    collect(30, 2000, 1'b0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
    total++; if (got_n !== 11) begin bad++; $display("FAIL bp_count: got %0d want 11", got_n); end
    for (int k = 0; k < 11 && k < got_n; k++) begin
      total++;
      if (got_data[k] !== exp128[10-k]) begin
        bad++; $display("FAIL bp_key%0d: got %h want %h", 10-k, got_data[k], exp128[10-k]);
      end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_rejected_starts();
    int errs;
    start_key(2'b00, KEY128);
    repeat (4) @(negedge clk);
    start_key(2'b10, KEY256);
    repeat (15) @(negedge clk);
    start_key(2'b11, KEY256);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rej_busy: got %b want 1", busy); end
    collect(100, 200, 1'b0);
    total++; if (got_n !== 11) begin bad++; $display("FAIL rej_count: got %0d want 11", got_n); end
    errs = 0;
    for (int k = 0; k < 11 && k < got_n; k++) if (got_data[k] !== exp128[10-k]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL rej_keys: got %0d wrong keys want 0", errs); end
    start_key(2'b11, KEY128);
    total++; if (err_len !== 1'b1) begin bad++; $display("FAIL bad_len_pulse: got %b want 1", err_len); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_len_busy: got %b want 0", busy); end
    @(negedge clk);
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL bad_len_once: got %b want 0", err_len); end
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      bad++; $display("FAIL bad_len_idle: got busy=%b valid=%b want 0/0", busy, rk_valid);
    end
  endtask

  task automatic test_reset_midway();
    int viol;
    int errs;
    bit found;
    start_key(2'b00, KEY128);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || err_len !== 1'b0) begin
      bad++; $display("FAIL rst_fwd: got busy=%b valid=%b err=%b want 0/0/0", busy, rk_valid, err_len);
    end
    viol = 0;
    rk_ready = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (rk_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL rst_fwd_quiet: got %0d active cycles want 0", viol); end

    start_key(2'b00, KEY128);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rk_valid && rk_round == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_r5_reach: got %b want 1", found); end
    rk_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 || rk_data !== 128'h0 ||
        rk_round !== 4'd0) begin
      bad++; $display("FAIL rst_rev: got busy=%b valid=%b last=%b round=%0d data=%h want all 0",
                      busy, rk_valid, rk_last, rk_round, rk_data);
    end

    start_key(2'b00, KEY128);
    collect(100, 200, 1'b0);
    total++; if (got_n !== 11) begin bad++; $display("FAIL rst_rerun_count: got %0d want 11", got_n); end
    errs = 0;
    for (int k = 0; k < 11 && k < got_n; k++) if (got_data[k] !== exp128[10-k]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL rst_rerun_keys: got %0d wrong keys want 0", errs); end
  endtask

  initial begin
    exp128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    exp128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    exp128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    exp128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    exp128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    exp128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    exp128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    exp128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    exp128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    exp128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    exp128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_rejected_starts();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
